// File: rtl/pll_lock_supervisor.sv
// PLL bring-up/lock supervisor: pulses PLL resets, waits for stable lock, then releases
// per-domain resets in a staggered order. Optional macro PLL_SOFT_RESTART_EN adds restart_i.
module pll_lock_supervisor #(
  parameter int unsigned NUM_CH           = 2,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned CH_STAGGER_CYC   = 64,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic              clkin,
  input  logic              reset,
`ifdef PLL_SOFT_RESTART_EN
  input  logic              restart_i,
`endif
  input  logic [NUM_CH-1:0] pll_lock_i,
  output logic [NUM_CH-1:0] pll_reset_o,
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic              all_ready_o,
  output logic              fault_o,
  output logic [7:0]        retry_cnt_o
);

  localparam int unsigned RelMax  = (NUM_CH - 1) * CH_STAGGER_CYC;
  localparam int unsigned CntMax0 = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC
                                                                     : LOCK_TIMEOUT_CYC;
  localparam int unsigned CntMax  = (CntMax0 > RelMax) ? CntMax0 : RelMax;
  localparam int unsigned CntW    = $clog2(CntMax) + 1;
  localparam int unsigned StbW    = $clog2(LOCK_STABLE_CYC) + 1;

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StRelease,
    StRun,
    StFault
  } state_e;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic              lock_s;

  always_ff @(posedge clkin) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pll_lock_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign lock_s = &sync_q[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [StbW-1:0]   stable_q, stable_d;
  logic [7:0]        fail_q, fail_d;
  logic [7:0]        retry_q, retry_d;
  logic              pll_rst_q, pll_rst_d;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;
  logic [7:0]        retry_inc;
  logic              lock_lost;
  logic              restart;

`ifdef PLL_SOFT_RESTART_EN
  assign restart = restart_i && (state_q != StResetPll);
`else
  assign restart = 1'b0;
`endif

  assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
  assign lock_lost = !lock_s && (state_q inside {StRelease, StRun});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stable_d  = '0;
    fail_d    = fail_q;
    retry_d   = retry_q;
    pll_rst_d = pll_rst_q;
    ch_rst_d  = ch_rst_q;
    ready_d   = ready_q;
    fault_d   = fault_q;

    unique case (state_q)
      StResetPll: begin
        pll_rst_d = 1'b1;
        ch_rst_d  = '1;
        ready_d   = 1'b0;
        if (cnt_q == CntW'(PLL_RST_CYC - 1)) begin
          state_d   = StWaitLock;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        cnt_d    = cnt_q + CntW'(1);
        stable_d = lock_s ? stable_q + StbW'(1) : '0;
        // Reaching stable lock takes precedence over a coincident timeout.
        if (lock_s && stable_q == StbW'(LOCK_STABLE_CYC - 1)) begin
          state_d  = StRelease;
          cnt_d    = '0;
          stable_d = '0;
          fail_d   = '0;
        end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYC - 1)) begin
          cnt_d     = '0;
          stable_d  = '0;
          fail_d    = fail_q + 8'd1;
          retry_d   = retry_inc;
          pll_rst_d = 1'b1;
          if (fail_q + 8'd1 == 8'(MAX_RETRY)) begin
            state_d = StFault;
            fault_d = 1'b1;
          end else begin
            state_d = StResetPll;
          end
        end
      end
      StRelease: begin
        cnt_d = cnt_q + CntW'(1);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (cnt_q == CntW'(k * CH_STAGGER_CYC)) ch_rst_d[k] = 1'b0;
        end
        if (cnt_q == CntW'(RelMax)) begin
          state_d  = StRun;
          cnt_d    = '0;
          ch_rst_d = '0;
          ready_d  = 1'b1;
        end
      end
      StRun: begin
        ch_rst_d = '0;
        ready_d  = 1'b1;
      end
      StFault: begin
        pll_rst_d = 1'b1;
        ch_rst_d  = '1;
        fault_d   = 1'b1;
      end
      default: state_d = StResetPll;
    endcase

    // Lock loss re-sequences without touching the timeout fail count.
    if (lock_lost) begin
      state_d   = StResetPll;
      cnt_d     = '0;
      pll_rst_d = 1'b1;
      ch_rst_d  = '1;
      ready_d   = 1'b0;
      retry_d   = retry_inc;
    end

    if (restart) begin
      state_d   = StResetPll;
      cnt_d     = '0;
      stable_d  = '0;
      fail_d    = '0;
      retry_d   = retry_q;
      pll_rst_d = 1'b1;
      ch_rst_d  = '1;
      ready_d   = 1'b0;
      fault_d   = 1'b0;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q   <= StResetPll;
      cnt_q     <= '0;
      stable_q  <= '0;
      fail_q    <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      ch_rst_q  <= '1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      fail_q    <= fail_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      ch_rst_q  <= ch_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_reset_o = {NUM_CH{pll_rst_q}};
  assign ch_rst_o    = ch_rst_q;
  assign all_ready_o = ready_q;
  assign fault_o     = fault_q;
  assign retry_cnt_o = retry_q;

endmodule
